// File: rtl/fm_mul_arbiter_pkg.sv
// Shared constants and types for the mantissa multiply arbiter.
// Significand and product widths are fixed here; they are not parameters of the arbiter.
package fm_mul_arbiter_pkg;

    localparam int unsigned WSIG       = 23;
    localparam int unsigned PRODWIDTH  = 2 * (WSIG + 1);
    localparam int unsigned FM_MUL_LAT = 2;
    localparam int unsigned FM_NREQ    = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    // Requester-id width; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fm_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past the pointer,
// and the first set request wins.
module fm_rr_arb
    import fm_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = FM_NREQ,
    localparam int unsigned IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o,
    output logic            any_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = IDW'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fm_mul_arbiter.sv
// Shares one mantissa multiplier between NREQ requesters: grant, hold the operands
// for MUL_LAT cycles, then capture the product and return it tagged with the requester id.
module fm_mul_arbiter
    import fm_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = FM_NREQ,
    parameter int unsigned MUL_LAT = FM_MUL_LAT,
    localparam int unsigned IDW    = id_width(NREQ),
    localparam int unsigned SW     = WSIG + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SW-1:0]   opa_flat,
    input  logic [NREQ*SW-1:0]   opb_flat,
    output logic [NREQ-1:0]      gnt,
    output logic [SW-1:0]        mul_a,
    output logic [SW-1:0]        mul_b,
    input  logic [PRODWIDTH-1:0] mul_prod,
    input  logic                 mul_twoormore,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [PRODWIDTH-1:0] res_prod,
    output logic                 res_twoormore,
    output logic                 busy
);

    arb_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       id_q;
    logic [SW-1:0]        mul_a_q;
    logic [SW-1:0]        mul_b_q;
    logic                 res_valid_q;
    logic [IDW-1:0]       res_id_q;
    logic [PRODWIDTH-1:0] res_prod_q;
    logic                 res_two_q;
    logic                 busy_q;

    logic [NREQ-1:0]      arb_gnt;
    logic [IDW-1:0]       arb_id;
    logic                 arb_any;
    logic                 arb_live;

    fm_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .id_o  (arb_id),
        .any_o (arb_any)
    );

    // Arbitration is live in IDLE and DONE; held off while reset is asserted.
    assign arb_live = rst_n && (state_q != StWait);
    assign gnt      = arb_live ? arb_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
            res_two_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (arb_any) begin
                        // Indexed part-select keeps X on losing slices out of the datapath.
                        mul_a_q <= opa_flat[int'(arb_id)*SW +: SW];
                        mul_b_q <= opb_flat[int'(arb_id)*SW +: SW];
                        id_q    <= arb_id;
                        ptr_q   <= arb_id;
                        cnt_q   <= CNT_W'(MUL_LAT - 1);
                        state_q <= StWait;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StWait: begin
                    busy_q <= 1'b1;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        res_prod_q  <= mul_prod;
                        res_two_q   <= mul_twoormore;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign res_valid     = res_valid_q;
    assign res_id        = res_id_q;
    assign res_prod      = res_prod_q;
    assign res_twoormore = res_two_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fm_mul_arbiter.sv
// Directed bench for fm_mul_arbiter: a 4-requester/latency-2 instance plus
// latency-1 and latency-15 instances for the latency boundaries.
module tb_fm_mul_arbiter;
    import fm_mul_arbiter_pkg::*;

    localparam int unsigned W = WSIG + 1;
    localparam int unsigned P = PRODWIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Main instance: NREQ=4, MUL_LAT=2
    logic [3:0]   req;
    logic [4*W-1:0] opa, opb;
    logic [3:0]   gnt;
    logic [W-1:0] mul_a, mul_b;
    logic [P-1:0] mul_prod;
    logic         mul_two, res_valid, res_two, busy;
    logic [1:0]   res_id;
    logic [P-1:0] res_prod;

    assign mul_prod = {{(P-W){1'b0}}, mul_a} * {{(P-W){1'b0}}, mul_b};
    assign mul_two  = mul_prod[P-1];

    fm_mul_arbiter #(.NREQ(4), .MUL_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa_flat(opa), .opb_flat(opb),
        .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
        .mul_twoormore(mul_two), .res_valid(res_valid), .res_id(res_id),
        .res_prod(res_prod), .res_twoormore(res_two), .busy(busy)
    );

    // Latency-1 instance
    logic [1:0]   a_req, a_gnt;
    logic [2*W-1:0] a_opa, a_opb;
    logic [W-1:0] a_mul_a, a_mul_b;
    logic [P-1:0] a_mul_prod, a_res_prod;
    logic         a_mul_two, a_res_valid, a_res_two, a_busy;
    logic [0:0]   a_res_id;

    assign a_mul_prod = {{(P-W){1'b0}}, a_mul_a} * {{(P-W){1'b0}}, a_mul_b};
    assign a_mul_two  = a_mul_prod[P-1];

    fm_mul_arbiter #(.NREQ(2), .MUL_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req(a_req), .opa_flat(a_opa), .opb_flat(a_opb),
        .gnt(a_gnt), .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_prod(a_mul_prod),
        .mul_twoormore(a_mul_two), .res_valid(a_res_valid), .res_id(a_res_id),
        .res_prod(a_res_prod), .res_twoormore(a_res_two), .busy(a_busy)
    );

    // Latency-15 instance
    logic [1:0]   b_req, b_gnt;
    logic [2*W-1:0] b_opa, b_opb;
    logic [W-1:0] b_mul_a, b_mul_b;
    logic [P-1:0] b_mul_prod, b_res_prod;
    logic         b_mul_two, b_res_valid, b_res_two, b_busy;
    logic [0:0]   b_res_id;

    assign b_mul_prod = {{(P-W){1'b0}}, b_mul_a} * {{(P-W){1'b0}}, b_mul_b};
    assign b_mul_two  = b_mul_prod[P-1];

    fm_mul_arbiter #(.NREQ(2), .MUL_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(rst_n), .req(b_req), .opa_flat(b_opa), .opb_flat(b_opb),
        .gnt(b_gnt), .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_prod(b_mul_prod),
        .mul_twoormore(b_mul_two), .res_valid(b_res_valid), .res_id(b_res_id),
        .res_prod(b_res_prod), .res_twoormore(b_res_two), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Land 2 time units after the rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic       seen;
        logic       flag;
        logic [3:0] exp_g;
        logic [P-1:0] exp_p;
        logic [W-1:0] a_hold, b_hold;
        logic       a_unstable, b_unstable;
        int         d_a, d_b;

        req = '0; opa = 'x; opb = 'x;
        a_req = '0; a_opa = 'x; a_opb = 'x;
        b_req = '0; b_opa = 'x; b_opb = 'x;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_res_prod", 64'(res_prod), 64'd0);

        // Single request, 1.5 * 1.5; other slices left X
        opa[W-1:0] = 24'hC00000;
        opb[W-1:0] = 24'hC00000;
        req = 4'b0001;
        #1;
        chk("single_gnt", 64'(gnt), 64'b0001);
        chk("single_busy_idle", 64'(busy), 64'd0);
        step();
        req = 4'b0000;
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_gnt_wait", 64'(gnt), 64'd0);
        chk("single_mul_a", 64'(mul_a), 64'hC00000);
        chk("single_valid_c1", 64'(res_valid), 64'd0);
        step();
        chk("single_valid_c2", 64'(res_valid), 64'd0);
        step();
        chk("single_valid_c3", 64'(res_valid), 64'd1);
        chk("single_id", 64'(res_id), 64'd0);
        chk("single_prod", 64'(res_prod), 64'h9000_0000_0000);
        chk("single_two", 64'(res_two), 64'd1);
        step();
        chk("single_idle", 64'(busy), 64'd0);
        chk("single_strobe_1cyc", 64'(res_valid), 64'd0);
        chk("single_prod_hold", 64'(res_prod), 64'h9000_0000_0000);

        // Reset in the middle of WAIT
        req = 4'b0001;
        #1;
        step();
        req = 4'b0000;
        chk("midrst_busy_pre", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        req = 4'b0001;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_mul_a", 64'(mul_a), 64'd0);
        chk("midrst_prod", 64'(res_prod), 64'd0);
        chk("midrst_two", 64'(res_two), 64'd0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            step();
            seen |= res_valid;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);

        // All requesting: order 0,1,2,3,0, one grant every 3 cycles
        opa = {4{24'h800000}};
        opb = {24'h800000, 24'h800000, 24'hC00000, 24'h800000};
        req = 4'b1111;
        #1;
        chk("all_gnt0", 64'(gnt), 64'b0001);
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); flag |= |gnt;
            step(); flag |= |gnt;
            step();
            exp_p = (k % 4 == 1) ? 48'h6000_0000_0000 : 48'h4000_0000_0000;
            chk($sformatf("all_valid%0d", k), 64'(res_valid), 64'd1);
            chk($sformatf("all_id%0d", k), 64'(res_id), 64'(k % 4));
            chk($sformatf("all_prod%0d", k), 64'(res_prod), 64'(exp_p));
            if (k < 4) begin
                exp_g = 4'b0001 << ((k + 1) % 4);
                chk($sformatf("all_gnt%0d", k + 1), 64'(gnt), 64'(exp_g));
            end else begin
                req = 4'b0000;
            end
        end
        chk("all_no_gnt_in_wait", 64'(flag), 64'd0);
        step();
        chk("all_idle", 64'(busy), 64'd0);

        // Back-to-back: requester 2 alone
        req = 4'b0100;
        #1;
        chk("b2b_gnt", 64'(gnt), 64'b0100);
        flag = 1'b0;
        for (int r = 0; r < 3; r++) begin
            repeat (3) begin
                step();
                flag |= !busy;
            end
            chk($sformatf("b2b_valid%0d", r), 64'(res_valid), 64'd1);
            chk($sformatf("b2b_id%0d", r), 64'(res_id), 64'd2);
            chk($sformatf("b2b_gnt%0d", r), 64'(gnt), 64'b0100);
        end
        req = 4'b0000;
        chk("b2b_busy_held", 64'(flag), 64'd0);
        step();
        chk("b2b_idle", 64'(busy), 64'd0);

        // Drop before grant: pointer at 2, so requester 1 wins over 2
        req = 4'b0110;
        #1;
        chk("drop_gnt", 64'(gnt), 64'b0010);
        step();
        req = 4'b0000;
        repeat (2) step();
        chk("drop_valid", 64'(res_valid), 64'd1);
        chk("drop_id", 64'(res_id), 64'd1);
        flag = 1'b0;
        repeat (4) begin
            step();
            flag |= gnt[2] | res_valid;
        end
        chk("drop_no_req2", 64'(flag), 64'd0);
        chk("drop_idle", 64'(busy), 64'd0);

        // Latency boundaries: MUL_LAT=1 and MUL_LAT=15
        a_opa[W-1:0] = 24'hA00000; a_opb[W-1:0] = 24'h800000;
        b_opa[W-1:0] = 24'hA00000; b_opb[W-1:0] = 24'h800000;
        a_req = 2'b01;
        b_req = 2'b01;
        #1;
        chk("lat1_gnt", 64'(a_gnt), 64'b01);
        chk("lat15_gnt", 64'(b_gnt), 64'b01);
        d_a = 0; d_b = 0;
        a_unstable = 1'b0; b_unstable = 1'b0;
        a_hold = '0; b_hold = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (cyc == 1) begin
                a_req = 2'b00;
                b_req = 2'b00;
                a_hold = a_mul_a;
                b_hold = b_mul_a;
            end
            if (d_a == 0 && a_res_valid) d_a = cyc;
            if (d_b == 0 && b_res_valid) d_b = cyc;
            if (d_a == 0 && a_mul_a !== a_hold) a_unstable = 1'b1;
            if (d_b == 0 && b_mul_a !== b_hold) b_unstable = 1'b1;
        end
        chk("lat1_dist", 64'(d_a), 64'd2);
        chk("lat15_dist", 64'(d_b), 64'd16);
        chk("lat1_stable", 64'(a_unstable), 64'd0);
        chk("lat15_stable", 64'(b_unstable), 64'd0);
        chk("lat15_hold_a", 64'(b_hold), 64'hA00000);
        chk("lat1_prod", 64'(a_res_prod), 64'h5000_0000_0000);
        chk("lat15_prod", 64'(b_res_prod), 64'h5000_0000_0000);
        chk("lat15_two", 64'(b_res_two), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
